// File: rtl/down_counter_ld.sv
// down_counter_ld: loadable binary down counter with borrow-out (bo = counter==0).
// Define DOWN_COUNTER_RELOAD_EN to reload the last loaded din on underflow instead of wrapping.
module down_counter_ld #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic             bo,
  output logic [WIDTH-1:0] counter
);
  logic [WIDTH-1:0] under;
  logic [WIDTH-1:0] nxt;
`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload;
  always_ff @(posedge clk or negedge rst)
    if (!rst) reload <= '0;
    else if (ld) reload <= din;
  assign under = bo ? reload : counter - WIDTH'(1);
`else
  assign under = counter - WIDTH'(1);
`endif
  assign bo = counter == '0;
  always_comb nxt = ld ? din : en ? under : counter;
  always_ff @(posedge clk or negedge rst)
    if (!rst) counter <= '0;
    else counter <= nxt;
endmodule

// File: tb/tb_down_counter_ld.sv
// tb_down_counter_ld: directed self-checking bench for down_counter_ld, including a two-stage cascade.
module tb_down_counter_ld;
  logic clk = 0, rst, en, ld, bo, c_ld, c_en, lo_bo, hi_bo, hi_en;
  logic [3:0] din, counter, lo_cnt, hi_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  down_counter_ld #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .en(en), .ld(ld), .din(din), .bo(bo), .counter(counter));

  assign hi_en = lo_bo & c_en;
  down_counter_ld #(.WIDTH(4)) lo (.clk(clk), .rst(rst), .en(c_en), .ld(c_ld), .din(4'd0), .bo(lo_bo), .counter(lo_cnt));
  down_counter_ld #(.WIDTH(4)) hi (.clk(clk), .rst(rst), .en(hi_en), .ld(c_ld), .din(4'd0), .bo(hi_bo), .counter(hi_cnt));

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; en = 0; ld = 0; din = 0; c_ld = 0; c_en = 0;
    #3;
    chk("rst_cnt", 16'(counter), 16'd0);
    chk("rst_bo", 16'(bo), 16'd1);
    step();
    rst = 1;
    ld = 1; din = 9;
    step();
    ld = 0;
    chk("ld9_cnt", 16'(counter), 16'd9);
    chk("ld9_bo", 16'(bo), 16'd0);
    #2 rst = 0;
    #1;
    chk("arst_cnt", 16'(counter), 16'd0);
    chk("arst_bo", 16'(bo), 16'd1);
    step();
    rst = 1;
    ld = 1; din = 5; en = 1;
    step();
    ld = 0;
    chk("ld5_cnt", 16'(counter), 16'd5);
    chk("ld5_bo", 16'(bo), 16'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("dec%0d_cnt", i), 16'(counter), 16'(5 - i));
      chk($sformatf("dec%0d_bo", i), 16'(bo), 16'(i == 5));
    end
    step();
`ifdef DOWN_COUNTER_RELOAD_EN
    chk("under_cnt", 16'(counter), 16'd5);
`else
    chk("under_cnt", 16'(counter), 16'd15);
`endif
    chk("under_bo", 16'(bo), 16'd0);
    ld = 1; din = 0; en = 0;
    step();
    chk("ld0_cnt", 16'(counter), 16'd0);
    chk("ld0_bo", 16'(bo), 16'd1);
    din = 3; en = 1;
    step();
    ld = 0; en = 0;
    chk("prio_cnt", 16'(counter), 16'd3);
    chk("prio_bo", 16'(bo), 16'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("hold%0d", i), 16'(counter), 16'd3);
    end
    c_ld = 1;
    step();
    c_ld = 0;
    chk("casc_ld", {8'd0, hi_cnt, lo_cnt}, 16'h00);
    c_en = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
`ifdef DOWN_COUNTER_RELOAD_EN
      chk($sformatf("casc%0d", i), {8'd0, hi_cnt, lo_cnt}, 16'h00);
`else
      chk($sformatf("casc%0d", i), {8'd0, hi_cnt, lo_cnt}, i == 17 ? 16'hEF : 16'(16'hFF - (i - 1)));
`endif
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
